// File: rtl/dsp_result_collector.sv
// Rounds, shifts and saturates DSP MAC results, then buffers them in a small
// FIFO behind a valid/ready stream with a sticky drop (overflow) flag.
module dsp_result_collector #(
  parameter int WIDTH      = 16,
  parameter int OUT_WIDTH  = 16,
  parameter int SHIFT_BITS = 5,
  parameter int DEPTH      = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [2*WIDTH-1:0]       res_data,
  input  logic                     res_valid,
  input  logic [SHIFT_BITS-1:0]    rnd_shift,
  input  logic                     sat_en,
  input  logic                     clear_ovf,
  output logic [OUT_WIDTH-1:0]     m_data,
  output logic                     m_sat,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = 2*WIDTH + 1;
  localparam logic signed [TW-1:0] SAT_MAX = {{(TW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [TW-1:0] SAT_MIN = {{(TW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  logic signed [TW-1:0]  w_ext;
  logic signed [TW-1:0]  w_rnd;
  logic signed [TW-1:0]  w_t;
  logic                  r_s1_valid;
  logic signed [TW-1:0]  r_s1_t;
  logic                  r_s1_sat_en;

  logic [OUT_WIDTH-1:0]  w_wr_data;
  logic                  w_wr_sat;

  logic [OUT_WIDTH-1:0]  r_mem_data [DEPTH];
  logic                  r_mem_sat  [DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [AW-1:0]         w_rd_ptr_next;
  logic [AW:0]           r_count;
  logic [AW:0]           w_count_next;
  logic                  w_full;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_drop;
  logic [OUT_WIDTH-1:0]  w_head_data;
  logic                  w_head_sat;
  logic [OUT_WIDTH-1:0]  r_m_data;
  logic                  r_m_sat;
  logic                  r_overflow;

  // One extra bit of headroom keeps the round-half-up add from wrapping.
  always_comb begin
    w_ext = {res_data[2*WIDTH-1], res_data};
    w_rnd = '0;
    if (rnd_shift != '0) begin
      w_rnd = TW'(1) << (rnd_shift - 1'b1);
    end
    w_t = (w_ext + w_rnd) >>> rnd_shift;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_t      <= '0;
      r_s1_sat_en <= 1'b0;
    end else begin
      r_s1_valid <= res_valid;
      if (res_valid) begin
        r_s1_t      <= w_t;
        r_s1_sat_en <= sat_en;
      end
    end
  end

  always_comb begin
    w_wr_data = r_s1_t[OUT_WIDTH-1:0];
    w_wr_sat  = 1'b0;
    if (r_s1_sat_en) begin
      if (r_s1_t > SAT_MAX) begin
        w_wr_data = {1'b0, {(OUT_WIDTH-1){1'b1}}};
        w_wr_sat  = 1'b1;
      end else if (r_s1_t < SAT_MIN) begin
        w_wr_data = {1'b1, {(OUT_WIDTH-1){1'b0}}};
        w_wr_sat  = 1'b1;
      end
    end
  end

  assign m_valid = (r_count != '0);
  assign w_full  = (r_count == (AW+1)'(DEPTH));
  assign w_pop   = m_valid && m_ready;
  assign w_push  = r_s1_valid && (!w_full || w_pop);
  assign w_drop  = r_s1_valid && w_full && !w_pop;

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + 1'b1;
    end else if (w_pop && !w_push) begin
      w_count_next = r_count - 1'b1;
    end
    w_rd_ptr_next = r_rd_ptr + AW'(w_pop);
  end

  // The head register must pick up a sample written this cycle when it lands
  // exactly at the next read position (empty FIFO, or last entry popping).
  always_comb begin
    w_head_data = r_mem_data[w_rd_ptr_next];
    w_head_sat  = r_mem_sat[w_rd_ptr_next];
    if (w_push && (r_wr_ptr == w_rd_ptr_next)) begin
      w_head_data = w_wr_data;
      w_head_sat  = w_wr_sat;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= w_wr_data;
      r_mem_sat[r_wr_ptr]  <= w_wr_sat;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_m_data   <= '0;
      r_m_sat    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      r_rd_ptr <= w_rd_ptr_next;
      r_count  <= w_count_next;
      if (w_count_next != '0) begin
        r_m_data <= w_head_data;
        r_m_sat  <= w_head_sat;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (clear_ovf) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign m_data   = r_m_data;
  assign m_sat    = r_m_sat;
  assign count    = r_count;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_dsp_result_collector.sv
// Directed self-checking bench for dsp_result_collector (16/16, depth 4).
module tb_dsp_result_collector;

  logic        clk;
  logic        rst;
  logic [31:0] res_data;
  logic        res_valid;
  logic [4:0]  rnd_shift;
  logic        sat_en;
  logic        clear_ovf;
  logic [15:0] m_data;
  logic        m_sat;
  logic        m_valid;
  logic        m_ready;
  logic [2:0]  count;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  dsp_result_collector #(
    .WIDTH(16), .OUT_WIDTH(16), .SHIFT_BITS(5), .DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .res_data(res_data), .res_valid(res_valid),
    .rnd_shift(rnd_shift), .sat_en(sat_en), .clear_ovf(clear_ovf),
    .m_data(m_data), .m_sat(m_sat), .m_valid(m_valid), .m_ready(m_ready),
    .count(count), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; res_data = '0; res_valid = 1'b0; rnd_shift = '0;
    sat_en = 1'b1; clear_ovf = 1'b0; m_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %b exp 0", m_valid); end
    checks++; if (m_data !== 16'h0) begin errors++; $display("FAIL reset_m_data got %h exp 0000", m_data); end
    checks++; if (m_sat !== 1'b0) begin errors++; $display("FAIL reset_m_sat got %b exp 0", m_sat); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", overflow); end
    $display("test_reset done");
  endtask

  task automatic test_passthrough();
    rnd_shift = 5'd0; sat_en = 1'b1; m_ready = 1'b1;
    res_data = 32'h0000_1234; res_valid = 1'b1;
    tick();
    res_valid = 1'b0;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL pass_early_valid got %b exp 0", m_valid); end
    tick();
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL pass_valid got %b exp 1", m_valid); end
    checks++; if (m_data !== 16'h1234) begin errors++; $display("FAIL pass_data got %h exp 1234", m_data); end
    checks++; if (m_sat !== 1'b0) begin errors++; $display("FAIL pass_sat got %b exp 0", m_sat); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL pass_count got %0d exp 1", count); end
    tick();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL pass_count_after_pop got %0d exp 0", count); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL pass_valid_after_pop got %b exp 0", m_valid); end
    m_ready = 1'b0;
    $display("test_passthrough done");
  endtask

  task automatic test_round();
    logic [31:0] din  [3] = '{32'h0000_0018, 32'hFFFF_FFE8, 32'h7FFF_FFFF};
    logic [15:0] dexp [3] = '{16'h0002, 16'hFFFF, 16'h7FFF};
    logic        sexp [3] = '{1'b0, 1'b0, 1'b1};
    rnd_shift = 5'd4; sat_en = 1'b1; m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      res_data = din[i]; res_valid = 1'b1;
      tick();
    end
    res_valid = 1'b0;
    tick();
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL round_count got %0d exp 3", count); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (m_data !== dexp[i]) begin errors++; $display("FAIL round_data[%0d] got %h exp %h", i, m_data, dexp[i]); end
      checks++; if (m_sat !== sexp[i]) begin errors++; $display("FAIL round_sat[%0d] got %b exp %b", i, m_sat, sexp[i]); end
      m_ready = 1'b1; tick(); m_ready = 1'b0;
    end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL round_drained got %b exp 0", m_valid); end
    $display("test_round done");
  endtask

  task automatic test_saturate();
    logic [31:0] din  [4] = '{32'h0001_2345, 32'hFFFE_0000, 32'h0001_2345, 32'hFFFE_0000};
    logic        sen  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [15:0] dexp [4] = '{16'h7FFF, 16'h8000, 16'h2345, 16'h0000};
    logic        sexp [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    rnd_shift = 5'd0; m_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      res_data = din[i]; sat_en = sen[i]; res_valid = 1'b1;
      tick();
    end
    res_valid = 1'b0; sat_en = 1'b1;
    tick();
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL sat_count got %0d exp 4", count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL sat_overflow got %b exp 0", overflow); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (m_data !== dexp[i]) begin errors++; $display("FAIL sat_data[%0d] got %h exp %h", i, m_data, dexp[i]); end
      checks++; if (m_sat !== sexp[i]) begin errors++; $display("FAIL sat_flag[%0d] got %b exp %b", i, m_sat, sexp[i]); end
      m_ready = 1'b1; tick(); m_ready = 1'b0;
    end
    $display("test_saturate done");
  endtask

  task automatic test_overflow();
    rnd_shift = 5'd0; sat_en = 1'b1; m_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      res_data = 32'(i); res_valid = 1'b1;
      tick();
    end
    res_valid = 1'b0;
    tick();
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL ovf_count got %0d exp 4", count); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", overflow); end
    // Head must not move while the consumer stalls.
    tick();
    checks++; if (m_data !== 16'h0001) begin errors++; $display("FAIL ovf_stall_data got %h exp 0001", m_data); end
    for (int i = 1; i <= 4; i++) begin
      checks++; if (m_data !== 16'(i)) begin errors++; $display("FAIL ovf_drain[%0d] got %h exp %h", i, m_data, 16'(i)); end
      m_ready = 1'b1; tick(); m_ready = 1'b0;
    end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL ovf_drained got %b exp 0", m_valid); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", overflow); end
    clear_ovf = 1'b1; tick(); clear_ovf = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b exp 0", overflow); end
    $display("test_overflow done");
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_q [$];
    int          guard;
    rnd_shift = 5'd0; sat_en = 1'b1; m_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      res_data = 32'(16 + i); res_valid = 1'b1; exp_q.push_back(16'(16 + i));
      tick();
    end
    res_valid = 1'b0;
    tick();
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL b2b_fill_count got %0d exp 4", count); end
    for (int cyc = 0; cyc <= 8; cyc++) begin
      res_valid = (cyc < 8);
      res_data  = 32'(32 + cyc);
      if (cyc < 8) exp_q.push_back(16'(32 + cyc));
      m_ready = (cyc >= 1);
      if (m_valid && m_ready) begin
        checks++; if (m_data !== exp_q[0]) begin errors++; $display("FAIL b2b_data cyc %0d got %h exp %h", cyc, m_data, exp_q[0]); end
        void'(exp_q.pop_front());
      end
      tick();
      if (cyc >= 1) begin
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL b2b_count cyc %0d got %0d exp 4", cyc, count); end
      end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL b2b_overflow cyc %0d got %b exp 0", cyc, overflow); end
    end
    res_valid = 1'b0;
    guard = 0;
    while (m_valid && guard < 16) begin
      checks++; if (m_data !== exp_q[0]) begin errors++; $display("FAIL b2b_drain got %h exp %h", m_data, exp_q[0]); end
      void'(exp_q.pop_front());
      tick();
      guard++;
    end
    m_ready = 1'b0;
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL b2b_leftover got %0d exp 0", exp_q.size()); end
    $display("test_back_to_back done");
  endtask

  task automatic test_reset_mid();
    rnd_shift = 5'd0; sat_en = 1'b1; m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      res_data = 32'(64 + i); res_valid = 1'b1;
      tick();
    end
    res_valid = 1'b0;
    checks++; if (count !== 3'd2) begin errors++; $display("FAIL rmid_pre_count got %0d exp 2", count); end
    #2 rst = 1'b1;
    #1;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b exp 0", m_valid); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL rmid_count got %0d exp 0", count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rmid_overflow got %b exp 0", overflow); end
    checks++; if (m_data !== 16'h0) begin errors++; $display("FAIL rmid_data got %h exp 0000", m_data); end
    tick();
    rst = 1'b0;
    tick();
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rmid_inflight_lost got %b exp 0", m_valid); end
    res_data = 32'h0000_0055; res_valid = 1'b1;
    tick();
    res_valid = 1'b0;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rmid_new_early got %b exp 0", m_valid); end
    tick();
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL rmid_new_valid got %b exp 1", m_valid); end
    checks++; if (m_data !== 16'h0055) begin errors++; $display("FAIL rmid_new_data got %h exp 0055", m_data); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL rmid_new_count got %0d exp 1", count); end
    m_ready = 1'b1; tick(); m_ready = 1'b0;
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_round();
    test_saturate();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dsp_result_collector.md
Name: dsp_result_collector

Overview:
- Downstream stage of the DSP multiply/MAC block; consumes its `2*WIDTH` signed result and its `compare_res` result-valid strobe.
- Rounds and shifts each valid result, then saturates it to `OUT_WIDTH`.
- Buffers the conditioned results in a small FIFO and presents them on a valid/ready stream to the next consumer.
- Provides a sticky overflow flag so lost results are never silent.

Parameters:
- `WIDTH`, 16, DSP operand width; input result is `2*WIDTH` bits signed.
- `OUT_WIDTH`, 16, width of the conditioned output sample (`OUT_WIDTH <= 2*WIDTH`).
- `SHIFT_BITS`, 5, width of the rounding right-shift amount.
- `DEPTH`, 4, FIFO entries (power of 2, ≥2).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous active-high reset.
- `res_data`  in  2*WIDTH  signed DSP result (DSP `out`).
- `res_valid`  in  1  result-valid strobe (DSP `compare_res`); one result per high cycle.
- `rnd_shift`  in  SHIFT_BITS  arithmetic right-shift amount with round-half-up; quasi-static.
- `sat_en`  in  1  1 = saturate to `OUT_WIDTH`, 0 = truncate (keep low `OUT_WIDTH` bits).
- `clear_ovf`  in  1  synchronous clear of the `overflow` flag.
- `m_data`  out  OUT_WIDTH  head-of-FIFO sample.
- `m_sat`  out  1  head sample was clamped.
- `m_valid`  out  1  FIFO non-empty.
- `m_ready`  in  1  consumer accepts head when `m_valid && m_ready`.
- `count`  out  clog2(DEPTH)+1  current FIFO occupancy.
- `overflow`  out  1  sticky: at least one result dropped.

Behaviour:
- Reset (async assert, sync release): `m_valid`=0, `m_data`=0, `m_sat`=0, `count`=0, `overflow`=0; pointers and the pipeline valid bit cleared. Reset mid-operation discards buffered entries and any in-flight result.
- Stage 1, registered on `res_valid`:
  - `s = rnd_shift`.
  - If `s > 0`: `t = (sext(res_data) + (1 << (s-1))) >>> s`, computed in `2*WIDTH+1` bits so the rounding add never wraps.
  - If `s = 0`: `t = res_data`.
  - `s >= 2*WIDTH` is illegal (behaviour undefined).
- Saturation, combinational into the FIFO write:
  - With `sat_en`=1: `t > 2^(OUT_WIDTH-1)-1` gives `0x7F..F` and sat=1; `t < -2^(OUT_WIDTH-1)` gives `0x80..0` and sat=1; otherwise `t[OUT_WIDTH-1:0]` and sat=0.
  - With `sat_en`=0: low bits, sat=0.
  - The sat bit is stored alongside the data.
- Latency: `res_valid` at edge t → entry written at edge t+1 → `m_valid`/`m_data` visible after edge t+2 when the FIFO was empty. Back-to-back `res_valid` sustains one write per cycle.
- Push: stage-1 valid and (not full, or pop in the same cycle) → write.
- Pop: `m_valid && m_ready` → read pointer advances. Pointers wrap modulo `DEPTH`.
- `count` update: +1 on push only, −1 on pop only, unchanged on simultaneous push and pop.
- Full with push and no pop: the sample is dropped, `overflow` is set, and FIFO contents are unchanged.
- Full with push and pop in the same cycle: both occur, `count` stays `DEPTH`, no overflow.
- Empty with pop attempt: no effect (`m_valid`=0).
- `overflow` stays set until `clear_ovf`. If `clear_ovf` and a new drop occur in the same cycle, set wins.
- `m_data`/`m_sat` always show the head entry. When empty they hold their last value; consumers must qualify them with `m_valid`.
- `m_data`/`m_sat` are stable while `m_valid && !m_ready`.
- `rnd_shift`/`sat_en` are sampled in the cycle the result is processed. Changing them mid-stream affects only subsequent results.

Test Plan (WIDTH=16, OUT_WIDTH=16, DEPTH=4):
1. `rnd_shift`=0, `sat_en`=1, `m_ready`=1, `res_data`=0x00001234 with `res_valid` pulse at edge t → `m_valid`=1 after edge t+2, `m_data`=0x1234, `m_sat`=0; `count` returns to 0 after the pop.
2. `rnd_shift`=4: `res_data`=0x00000018 → `m_data`=0x0002. `res_data`=0xFFFFFFE8 (−24) → 0xFFFF (−1). `res_data`=0x7FFFFFFF → no wrap, saturates to 0x7FFF with `m_sat`=1.
3. `rnd_shift`=0, `sat_en`=1: 0x00012345 → 0x7FFF, `m_sat`=1; 0xFFFE0000 → 0x8000, `m_sat`=1. Same inputs with `sat_en`=0 → 0x2345 and 0x0000, `m_sat`=0.
4. `m_ready`=0, five consecutive results 1..5 → `count`=4, `overflow`=1. Draining yields 1,2,3,4 in order; result 5 is lost. Pulse `clear_ovf` → `overflow`=0.
5. FIFO full, `m_ready`=1 with continuous `res_valid` for 8 cycles → `count` holds 4, `overflow` stays 0, output sequence matches input order.
6. Two entries buffered plus one in flight, assert `rst` asynchronously mid-cycle → `m_valid`=0, `count`=0, `overflow`=0 immediately. After release, the first new result appears 2 cycles after its `res_valid`.
